mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-master, one-slave arbiter for the processor's sel/ack memory bus. It lets the processor (m0) and a second bus master (m1, e.g. a DMA or video fetch unit) share a single memory/peripheral port. Arbitration is round-robin or fixed-priority. Request fields are registered toward the slave, and a bus timeout returns an error completion so a dead slave cannot hang a master.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins ties
TIMEOUT_CYCLES, 256, slave cycles allowed per transfer before forced completion; 0 disables the timeout
TIMEOUT_DATA, 32'hDEADBEEF, read data returned to the master on a timed-out transfer

Ports:
clk  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
m0_sel_i  in  1  master 0 request; held until its ack
m0_addr_i  in  32  master 0 byte address
m0_we_i  in  1  master 0 write enable
m0_wr_mask_i  in  4  master 0 byte write mask
m0_data_out_i  in  32  master 0 write data
m0_data_in_o  out  32  read data to master 0
m0_ack_o  out  1  completion pulse to master 0
m1_sel_i .. m1_ack_o  same set as m0, for master 1
s_sel_o  out  1  request to slave
s_addr_o  out  32  slave address
s_we_o  out  1  slave write enable
s_wr_mask_o  out  4  slave byte mask
s_data_out_o  out  32  slave write data
s_data_in_i  in  32  slave read data
s_ack_i  in  1  slave completion
owner_o  out  1  index of the current or last granted master
busy_o  out  1  high in BUSY and ERR
timeout_o  out  1  one-cycle pulse when a transfer times out

Behaviour:
- Clock/reset: one clock, clk. Reset is reset_i, asynchronous and active-high.
- Reset values: state=IDLE, s_sel_o=0, s_we_o=0, s_addr_o=0, s_wr_mask_o=4'b1111, s_data_out_o=0, owner_o=1 (m0 wins first tie), busy_o=0, timeout_o=0, timer=0.
- Reset mid-transfer: returns to IDLE immediately. The in-flight transfer is dropped and no ack is issued.
- States: IDLE, BUSY, ERR.
- IDLE:
  - Sample m0_sel_i and m1_sel_i.
  - If only one is high, grant it.
  - If both are high and PRIORITY_MODE=0, grant the master that is not owner_o. If PRIORITY_MODE=1, grant m0.
  - On grant, at the same edge: latch that master's addr/we/wr_mask/data_out into the s_* registers, set s_sel_o=1, set owner_o to the winner, clear timer, go to BUSY.
  - Latency: master sel at edge t gives s_sel_o high after edge t (1 cycle).
- BUSY:
  - s_* outputs are held stable.
  - If s_ack_i=1: combinationally assert m{owner}_ack_o=1 that cycle. At the edge, s_sel_o<=0, s_we_o<=0, go to IDLE.
  - Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: s_sel_o<=0, s_we_o<=0, go to ERR.
  - Else timer<=timer+1. The timer is $clog2(TIMEOUT_CYCLES+1) bits wide and never wraps.
- ERR (one cycle): m{owner}_ack_o=1, m{owner}_data_in_o=TIMEOUT_DATA, timeout_o=1, then go to IDLE. A late s_ack_i arriving in ERR or IDLE is ignored.
- Read data: outside ERR, m0_data_in_o and m1_data_in_o both equal s_data_in_i combinationally. Only the owner's ack is meaningful.
- The non-owner's ack is always 0. s_ack_i in IDLE is never forwarded.
- Masters drop sel on the edge that samples their ack, as the processor does. The arbiter is back in IDLE on that same edge, so no spurious re-grant occurs.
- A master that raises sel during another master's BUSY waits, and sees the grant in the IDLE cycle after completion.
- Minimum back-to-back turnaround is one IDLE cycle between transfers.
- Requester fields are sampled only at grant. Master changes during BUSY have no effect.

Test Plan:
- Single read: m0 reads 0x100, slave acks after 3 cycles with 0x12345678 -> s_sel_o rises 1 cycle after m0_sel_i; m0_ack_o pulses once with m0_data_in_o=0x12345678; m1_ack_o stays 0.
- Round-robin: m0 and m1 request together from reset, continuously, PRIORITY_MODE=0 -> grant order m0,m1,m0,m1, with one IDLE cycle between grants.
- Fixed priority: same stimulus with PRIORITY_MODE=1 -> m0 is always granted; m1 is granted only once m0 stops requesting.
- Write passthrough: m1 writes addr 0x203, mask 4'b1000, data 0xAB000000; m1 alters its addr during BUSY -> slave sees the original latched values unchanged; m1_ack_o on s_ack_i.
- Timeout: TIMEOUT_CYCLES=8, slave never acks -> s_sel_o high for exactly 8 cycles; next cycle m0_ack_o=1, m0_data_in_o=0xDEADBEEF, timeout_o=1; a later s_ack_i is ignored.
- Async reset during BUSY: assert reset_i mid-cycle -> s_sel_o drops without a clock edge; no master ack; owner_o=1; next request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master, one-slave arbiter for the sel/ack memory bus.
// Round-robin or fixed-priority grant, registered slave request, timeout error completion.
module mem_arbiter #(
  parameter int          PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_i,

  input  logic        m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_wr_mask_i,
  input  logic [31:0] m0_data_out_i,
  output logic [31:0] m0_data_in_o,
  output logic        m0_ack_o,

  input  logic        m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_wr_mask_i,
  input  logic [31:0] m1_data_out_i,
  output logic [31:0] m1_data_in_o,
  output logic        m1_ack_o,

  output logic        s_sel_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_wr_mask_o,
  output logic [31:0] s_data_out_o,
  input  logic [31:0] s_data_in_i,
  input  logic        s_ack_i,

  output logic        owner_o,
  output logic        busy_o,
  output logic        timeout_o
);

  // A disabled timeout still keeps a 1-bit (saturating, otherwise unused) timer.
  localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer;
  logic          grant, grant_m1;
  logic          done;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state;
    grant    = 1'b0;
    grant_m1 = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_sel_i || m1_sel_i) begin
          grant = 1'b1;
          if (m0_sel_i && m1_sel_i) grant_m1 = (PRIORITY_MODE == 0) && !owner_o;
          else                      grant_m1 = m1_sel_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i)                                         state_d = IDLE;
        else if (TIMEOUT_CYCLES != 0 && timer == T_LAST)     state_d = ERR;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      s_sel_o      <= 1'b0;
      s_we_o       <= 1'b0;
      s_addr_o     <= '0;
      s_wr_mask_o  <= 4'b1111;
      s_data_out_o <= '0;
      owner_o      <= 1'b1;
      timer        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner_o      <= grant_m1;
            s_sel_o      <= 1'b1;
            s_addr_o     <= grant_m1 ? m1_addr_i     : m0_addr_i;
            s_we_o       <= grant_m1 ? m1_we_i       : m0_we_i;
            s_wr_mask_o  <= grant_m1 ? m1_wr_mask_i  : m0_wr_mask_i;
            s_data_out_o <= grant_m1 ? m1_data_out_i : m0_data_out_i;
            timer        <= '0;
          end
        end
        BUSY: begin
          if (state_d != BUSY) begin
            s_sel_o <= 1'b0;
            s_we_o  <= 1'b0;
          end else if (timer != T_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Completion is the slave ack while BUSY, or the forced error cycle; only the owner sees it.
  assign done         = (state == BUSY && s_ack_i) || (state == ERR);
  assign m0_ack_o     = done && !owner_o;
  assign m1_ack_o     = done &&  owner_o;
  assign m0_data_in_o = (state == ERR && !owner_o) ? TIMEOUT_DATA : s_data_in_i;
  assign m1_data_in_o = (state == ERR &&  owner_o) ? TIMEOUT_DATA : s_data_in_i;
  assign busy_o       = (state != IDLE);
  assign timeout_o    = (state == ERR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance run side by side
// against a transaction-level reference model, with directed and random traffic.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;
  localparam logic [31:0] TD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Master request fields are shared; sel is per instance since completion timing differs.
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic        m_we   [2];
  logic [3:0]  m_mask [2];
  logic        msel   [2][2];   // [instance][master]
  logic [31:0] s_rdata;
  logic        s_ack;

  logic [31:0] o_rdata[2][2];
  logic        o_ack  [2][2];
  logic        o_ssel [2];
  logic        o_swe  [2];
  logic        o_owner[2];
  logic        o_busy [2];
  logic        o_to   [2];
  logic [31:0] o_saddr[2];
  logic [31:0] o_sdata[2];
  logic [3:0]  o_smask[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.PRIORITY_MODE(g), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TD)) u_dut (
      .clk(clk), .reset_i(reset),
      .m0_sel_i(msel[g][0]), .m0_addr_i(m_addr[0]), .m0_we_i(m_we[0]),
      .m0_wr_mask_i(m_mask[0]), .m0_data_out_i(m_wdata[0]),
      .m0_data_in_o(o_rdata[g][0]), .m0_ack_o(o_ack[g][0]),
      .m1_sel_i(msel[g][1]), .m1_addr_i(m_addr[1]), .m1_we_i(m_we[1]),
      .m1_wr_mask_i(m_mask[1]), .m1_data_out_i(m_wdata[1]),
      .m1_data_in_o(o_rdata[g][1]), .m1_ack_o(o_ack[g][1]),
      .s_sel_o(o_ssel[g]), .s_addr_o(o_saddr[g]), .s_we_o(o_swe[g]),
      .s_wr_mask_o(o_smask[g]), .s_data_out_o(o_sdata[g]),
      .s_data_in_i(s_rdata), .s_ack_i(s_ack),
      .owner_o(o_owner[g]), .busy_o(o_busy[g]), .timeout_o(o_to[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;
  int sel_hi, to_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each instance is either idle, serving a transfer, or in its error cycle.
  typedef enum int {M_IDLE, M_XFER, M_ERR} phase_t;
  phase_t      ph     [2];
  bit          own    [2];
  int          waited [2];   // cycles the slave has been selected without acking
  logic [31:0] l_addr [2];
  logic [31:0] l_data [2];
  logic        l_we   [2];
  logic [3:0]  l_mask [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ph[d] = M_IDLE; own[d] = 1'b1; waited[d] = 0;
      l_addr[d] = '0; l_data[d] = '0; l_we[d] = 1'b0; l_mask[d] = 4'hF;
    end
  endtask

  function automatic bit e_ack(int d, int m);
    return (int'(own[d]) == m) && ((ph[d] == M_XFER && s_ack) || ph[d] == M_ERR);
  endfunction

  task automatic model_edge(input int d);
    bit r0, r1, w;
    r0 = msel[d][0];
    r1 = msel[d][1];
    case (ph[d])
      M_IDLE: if (r0 || r1) begin
        if (r0 && r1) w = (d == 1) ? 1'b0 : !own[d];
        else          w = r1;
        own[d] = w; ph[d] = M_XFER; waited[d] = 0;
        l_addr[d] = m_addr[w]; l_data[d] = m_wdata[w];
        l_we[d] = m_we[w]; l_mask[d] = m_mask[w];
      end
      M_XFER: begin
        if (s_ack)                        ph[d] = M_IDLE;
        else if (waited[d] + 1 == int'(TO)) ph[d] = M_ERR;
        else                              waited[d]++;
      end
      default: ph[d] = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("i%0d m%0d_ack", d, m), 32'(o_ack[d][m]), 32'(e_ack(d, m)));
        check($sformatf("i%0d m%0d_rdata", d, m), o_rdata[d][m],
              (ph[d] == M_ERR && int'(own[d]) == m) ? TD : s_rdata);
      end
      check($sformatf("i%0d s_sel", d),   32'(o_ssel[d]),  32'(ph[d] == M_XFER));
      check($sformatf("i%0d s_we", d),    32'(o_swe[d]),   32'(ph[d] == M_XFER && l_we[d]));
      check($sformatf("i%0d s_addr", d),  o_saddr[d],      l_addr[d]);
      check($sformatf("i%0d s_data", d),  o_sdata[d],      l_data[d]);
      check($sformatf("i%0d s_mask", d),  32'(o_smask[d]), 32'(l_mask[d]));
      check($sformatf("i%0d owner", d),   32'(o_owner[d]), 32'(own[d]));
      check($sformatf("i%0d busy", d),    32'(o_busy[d]),  32'(ph[d] != M_IDLE));
      check($sformatf("i%0d timeout", d), 32'(o_to[d]),    32'(ph[d] == M_ERR));
    end
  endtask

  // One clock cycle, entered and left at a falling edge. want[m] raises master m's sel if idle;
  // a master drops sel on the edge that samples its ack.
  task automatic step(input bit want0, input bit want1);
    bit ak[2][2];
    for (int d = 0; d < 2; d++) begin
      if (!msel[d][0] && want0) msel[d][0] = 1'b1;
      if (!msel[d][1] && want1) msel[d][1] = 1'b1;
    end
    #1;
    check_outputs();
    if (o_ssel[0]) sel_hi++;
    if (o_to[0])   to_pulses++;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) ak[d][m] = e_ack(d, m);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_edge(d);
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) if (ak[d][m]) msel[d][m] = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_master(input int m, input logic [31:0] a, input logic we,
                            input logic [3:0] mask, input logic [31:0] wd);
    m_addr[m] = a; m_we[m] = we; m_mask[m] = mask; m_wdata[m] = wd;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) set_master(m, '0, 1'b0, '0, '0);
    for (int d = 0; d < 2; d++) begin msel[d][0] = 1'b0; msel[d][1] = 1'b0; end
    s_rdata = '0;
    s_ack   = 1'b0;
    model_reset();

    // Reset state while reset is still held.
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Single read by m0, slave acks on the third cycle of the transfer.
    set_master(0, 32'h100, 1'b0, 4'hF, '0);
    s_rdata = 32'h12345678;
    step(1, 0);
    step(0, 0);
    step(0, 0);
    s_ack = 1'b1;
    step(0, 0);
    s_ack = 1'b0;
    step(0, 0);

    // Both masters request continuously, slave acks immediately.
    set_master(1, 32'h400, 1'b0, 4'hF, '0);
    s_ack = 1'b1;
    for (int i = 0; i < 12; i++) step(1, 1);
    for (int i = 0; i < 4; i++)  step(0, 1);
    s_ack = 1'b0;
    step(0, 0);

    // m1 write; its fields change during the transfer and must not reach the slave.
    set_master(1, 32'h203, 1'b1, 4'b1000, 32'hAB000000);
    step(0, 1);
    set_master(1, 32'hFFFF_0000, 1'b0, 4'b0001, 32'h0);
    step(0, 0);
    step(0, 0);
    s_ack = 1'b1;
    step(0, 0);
    s_ack = 1'b0;
    step(0, 0);

    // Timeout: slave never acks, then a late ack arrives and must be ignored.
    set_master(0, 32'h800, 1'b0, 4'hF, '0);
    sel_hi = 0;
    to_pulses = 0;
    step(1, 0);
    for (int i = 0; i < 12; i++) step(0, 0);
    s_ack = 1'b1;
    step(0, 0);
    step(0, 0);
    s_ack = 1'b0;
    check("timeout s_sel cycles", 32'(sel_hi), 32'(TO));
    check("timeout pulses", 32'(to_pulses), 32'd1);

    // Asynchronous reset in the middle of a transfer.
    step(1, 1);
    step(0, 0);
    #2;
    s_ack = 1'b1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst i%0d s_sel", d), 32'(o_ssel[d]),   32'd0);
      check($sformatf("rst i%0d busy", d),  32'(o_busy[d]),   32'd0);
      check($sformatf("rst i%0d owner", d), 32'(o_owner[d]),  32'd1);
      check($sformatf("rst i%0d ack0", d),  32'(o_ack[d][0]), 32'd0);
      check($sformatf("rst i%0d ack1", d),  32'(o_ack[d][1]), 32'd0);
    end
    model_reset();
    for (int d = 0; d < 2; d++) begin msel[d][0] = 1'b0; msel[d][1] = 1'b0; end
    s_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_master(1, 32'h300, 1'b0, 4'hF, '0);
    step(0, 1);
    s_ack = 1'b1;
    step(0, 0);
    s_ack = 1'b0;
    step(0, 0);

    // Random traffic: frequent acks first, then a slow slave that provokes timeouts.
    for (int i = 0; i < 800; i++) begin
      int pct;
      pct = (i < 400) ? 40 : 6;
      for (int m = 0; m < 2; m++)
        set_master(m, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      s_rdata = $urandom;
      s_ack   = ($urandom_range(0, 99) < pct);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
